// File: rtl/fp_issue_ctrl_pkg.sv
// Shared definitions for the FP issue controller: FPU opcodes, FSM states and
// strobe decode helpers.
package fp_issue_ctrl_pkg;

    localparam int unsigned FPOP_W = 3;

    typedef enum logic [FPOP_W-1:0] {
        FpAdd  = 3'd0,
        FpSub  = 3'd1,
        FpMul  = 3'd2,
        FpDiv  = 3'd3,
        FpSqrt = 3'd4
    } fp_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBusy,
        StWb
    } state_e;

    // Strobe vector layout is {fsqrt, fdiv, fmul, fsub, fadd}
    function automatic logic [2:0] strobe_count(input logic [4:0] s);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, s[i]};
        end
        return n;
    endfunction

    function automatic fp_op_e strobe_to_op(input logic [4:0] s);
        fp_op_e op;
        case (s)
            5'b00010: op = FpSub;
            5'b00100: op = FpMul;
            5'b01000: op = FpDiv;
            5'b10000: op = FpSqrt;
            default:  op = FpAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fp_timeout_counter.sv
// Cycle counter for the BUSY watchdog; expire flags the last allowed cycle.
module fp_timeout_counter #(
    parameter int unsigned LIMIT = 64,
    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expire = enable && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/fp_issue_ctrl.sv
// Captures one decoded FP op, issues it to the multi-cycle FPU, stalls the
// pipeline until completion and writes the result back to the FP register file.
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              fadd,
    input  logic              fsub,
    input  logic              fmul,
    input  logic              fdiv,
    input  logic              fsqrt,
    input  logic              FRegWrite,
    input  logic [4:0]        rd,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              flush,
    output logic              stall,
    output logic              fpu_valid,
    output logic [FPOP_W-1:0] fpu_op,
    output logic [XLEN-1:0]   fpu_a,
    output logic [XLEN-1:0]   fpu_b,
    input  logic              fpu_ready,
    input  logic              fpu_done,
    input  logic [XLEN-1:0]   fpu_result,
    output logic              fwb_en,
    output logic [4:0]        fwb_rd,
    output logic [XLEN-1:0]   fwb_data,
    output logic              err_illegal,
    output logic              err_timeout
);

    state_e          state_q, state_d;
    fp_op_e          op_q;
    logic [XLEN-1:0] a_q, b_q, data_q;
    logic [4:0]      rd_q;
    logic            wen_q, killed_q, illegal_q, timeout_q;
    logic [4:0]      strobes;
    logic [2:0]      n_strobes;
    logic            accept, handshake, busy, expire, timeout;

    assign strobes   = {fsqrt, fdiv, fmul, fsub, fadd};
    assign n_strobes = strobe_count(strobes);
    // A coincident flush kills the decode slot, so the op is never accepted
    assign accept    = (state_q == StIdle) && in_valid && (n_strobes == 3'd1) && !flush;
    assign handshake = (state_q == StReq) && !flush && fpu_ready;
    assign busy      = (state_q == StBusy);
    assign timeout   = busy && expire && !fpu_done;

    fp_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (handshake),
        .enable (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq: begin
                if (flush) state_d = StIdle;
                else if (fpu_ready) state_d = StBusy;
            end
            StBusy: begin
                if (fpu_done) state_d = StWb;
                else if (expire) state_d = StIdle;
            end
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall     = ((state_q != StIdle) && (state_q != StWb)) || accept;
        fpu_valid = (state_q == StReq);
        fwb_en    = (state_q == StWb) && wen_q && !killed_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= FpAdd;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            data_q    <= '0;
            killed_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= strobe_to_op(strobes);
                a_q   <= op_a;
                b_q   <= op_b;
                rd_q  <= rd;
                wen_q <= FRegWrite;
            end
            if (busy && fpu_done) begin
                data_q <= fpu_result;
            end
            // killed must not leak into the next op, so clear on every exit to IDLE
            if ((state_q == StWb) || timeout) begin
                killed_q <= 1'b0;
            end else if (busy && flush) begin
                killed_q <= 1'b1;
            end
            illegal_q <= (state_q == StIdle) && in_valid && (n_strobes > 3'd1);
            timeout_q <= timeout;
        end
    end

    assign fpu_op      = op_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fwb_rd      = rd_q;
    assign fwb_data    = data_q;
    assign err_illegal = illegal_q;
    assign err_timeout = timeout_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: issue, backpressure, illegal strobes,
// flush, timeout and asynchronous reset.
module tb_fp_issue_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, fadd, fsub, fmul, fdiv, fsqrt, FRegWrite, flush;
    logic [4:0]      rd;
    logic [XLEN-1:0] op_a, op_b, fpu_result;
    logic            fpu_ready, fpu_done;
    logic            stall, fpu_valid, fwb_en, err_illegal, err_timeout;
    logic [2:0]      fpu_op;
    logic [XLEN-1:0] fpu_a, fpu_b, fwb_data;
    logic [4:0]      fwb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_issue_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .fadd        (fadd),
        .fsub        (fsub),
        .fmul        (fmul),
        .fdiv        (fdiv),
        .fsqrt       (fsqrt),
        .FRegWrite   (FRegWrite),
        .rd          (rd),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .stall       (stall),
        .fpu_valid   (fpu_valid),
        .fpu_op      (fpu_op),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_ready   (fpu_ready),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .fwb_en      (fwb_en),
        .fwb_rd      (fwb_rd),
        .fwb_data    (fwb_data),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        in_valid = 0; fadd = 0; fsub = 0; fmul = 0; fdiv = 0; fsqrt = 0;
    endtask

    task automatic present(input logic [4:0] s, input logic [4:0] r,
                           input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; FRegWrite = 1; rd = r; op_a = a; op_b = b;
        {fsqrt, fdiv, fmul, fsub, fadd} = s;
    endtask

    initial begin
        rst = 0; clear_dec(); FRegWrite = 0; flush = 0; rd = '0;
        op_a = '0; op_b = '0; fpu_ready = 0; fpu_done = 0; fpu_result = '0;
        #3;
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_fpu_valid", {31'b0, fpu_valid}, 0);
        check("rst_fpu_op", {29'b0, fpu_op}, 0);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_fwb_en", {31'b0, fwb_en}, 0);
        check("rst_fwb_data", fwb_data, 0);
        check("rst_errs", {30'b0, err_illegal, err_timeout}, 0);
        #10 rst = 1;
        cyc();

        // 1: fadd, ready in REQ, done in third BUSY cycle
        present(5'b00001, 5'd5, 32'h3F800000, 32'h40000000);
        #1 check("t1_accept_stall", {31'b0, stall}, 1);
        cyc(); clear_dec(); fpu_ready = 1; #1;
        check("t1_fpu_valid", {31'b0, fpu_valid}, 1);
        check("t1_fpu_op", {29'b0, fpu_op}, 0);
        check("t1_fpu_a", fpu_a, 32'h3F800000);
        check("t1_fpu_b", fpu_b, 32'h40000000);
        check("t1_req_stall", {31'b0, stall}, 1);
        cyc(); fpu_ready = 0; #1;
        check("t1_busy_valid", {31'b0, fpu_valid}, 0);
        check("t1_busy_stall", {31'b0, stall}, 1);
        cyc(); cyc(); fpu_done = 1; fpu_result = 32'h40400000;
        cyc(); fpu_done = 0; #1;
        check("t1_wb_en", {31'b0, fwb_en}, 1);
        check("t1_wb_rd", {27'b0, fwb_rd}, 5);
        check("t1_wb_data", fwb_data, 32'h40400000);
        check("t1_wb_stall", {31'b0, stall}, 0);
        cyc();
        check("t1_wb_pulse", {31'b0, fwb_en}, 0);

        // 2: fdiv with ready low for 4 REQ cycles
        present(5'b01000, 5'd9, 32'h41200000, 32'h40A00000);
        cyc(); clear_dec(); #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_valid_%0d", i), {31'b0, fpu_valid}, 1);
            check($sformatf("t2_op_%0d", i), {29'b0, fpu_op}, 3);
            check($sformatf("t2_a_%0d", i), fpu_a, 32'h41200000);
            check($sformatf("t2_b_%0d", i), fpu_b, 32'h40A00000);
            check($sformatf("t2_stall_%0d", i), {31'b0, stall}, 1);
            cyc();
        end
        fpu_ready = 1;
        cyc(); fpu_ready = 0; #1;
        check("t2_busy_valid", {31'b0, fpu_valid}, 0);
        check("t2_busy_stall", {31'b0, stall}, 1);
        fpu_done = 1; fpu_result = 32'h40000000;
        cyc(); fpu_done = 0; #1;
        check("t2_wb_en", {31'b0, fwb_en}, 1);
        check("t2_wb_rd", {27'b0, fwb_rd}, 9);
        check("t2_wb_data", fwb_data, 32'h40000000);
        cyc();

        // 3: two strobes at once
        present(5'b00110, 5'd1, 32'h1, 32'h2);
        #1 check("t3_stall", {31'b0, stall}, 0);
        cyc(); clear_dec(); #1;
        check("t3_illegal", {31'b0, err_illegal}, 1);
        check("t3_valid", {31'b0, fpu_valid}, 0);
        check("t3_stall_after", {31'b0, stall}, 0);
        cyc();
        check("t3_illegal_pulse", {31'b0, err_illegal}, 0);
        check("t3_valid_after", {31'b0, fpu_valid}, 0);

        // 4: fsqrt flushed in BUSY, then a normal fadd
        present(5'b10000, 5'd3, 32'h40800000, 32'h0);
        cyc(); clear_dec(); fpu_ready = 1; #1;
        check("t4_op", {29'b0, fpu_op}, 4);
        cyc(); fpu_ready = 0; flush = 1;
        cyc(); flush = 0;
        cyc(); fpu_done = 1; fpu_result = 32'h40000000;
        cyc(); fpu_done = 0; #1;
        check("t4_wb_killed", {31'b0, fwb_en}, 0);
        check("t4_wb_stall", {31'b0, stall}, 0);
        cyc();
        check("t4_idle_valid", {31'b0, fpu_valid}, 0);
        present(5'b00001, 5'd7, 32'h3F800000, 32'h3F800000);
        #1 check("t4_next_accept", {31'b0, stall}, 1);
        cyc(); clear_dec(); fpu_ready = 1; #1;
        check("t4_next_valid", {31'b0, fpu_valid}, 1);
        check("t4_next_op", {29'b0, fpu_op}, 0);
        cyc(); fpu_ready = 0; fpu_done = 1; fpu_result = 32'h40000000;
        cyc(); fpu_done = 0; #1;
        check("t4_next_wb", {31'b0, fwb_en}, 1);
        check("t4_next_rd", {27'b0, fwb_rd}, 7);
        cyc();

        // 5: no done, watchdog fires after TO BUSY cycles
        present(5'b00001, 5'd11, 32'h1, 32'h2);
        cyc(); clear_dec(); fpu_ready = 1;
        cyc(); fpu_ready = 0; #1;
        for (int i = 0; i < TO; i++) begin
            check($sformatf("t5_busy_stall_%0d", i), {31'b0, stall}, 1);
            check($sformatf("t5_no_to_%0d", i), {31'b0, err_timeout}, 0);
            cyc();
        end
        check("t5_timeout", {31'b0, err_timeout}, 1);
        check("t5_stall_rel", {31'b0, stall}, 0);
        check("t5_no_wb", {31'b0, fwb_en}, 0);
        cyc();
        check("t5_timeout_pulse", {31'b0, err_timeout}, 0);
        check("t5_no_wb_after", {31'b0, fwb_en}, 0);

        // 6: asynchronous reset while BUSY
        present(5'b00100, 5'd2, 32'h12345678, 32'h9ABCDEF0);
        cyc(); clear_dec(); fpu_ready = 1;
        cyc(); fpu_ready = 0;
        cyc();
        #2 rst = 0;
        #1;
        check("t6_stall", {31'b0, stall}, 0);
        check("t6_valid", {31'b0, fpu_valid}, 0);
        check("t6_op", {29'b0, fpu_op}, 0);
        check("t6_a", fpu_a, 0);
        check("t6_rd", {27'b0, fwb_rd}, 0);
        check("t6_data", fwb_data, 0);
        #3 rst = 1;
        cyc();
        check("t6_idle_stall", {31'b0, stall}, 0);
        present(5'b00001, 5'd4, 32'h5, 32'h6);
        cyc(); clear_dec(); #1;
        check("t6_reissue", {31'b0, fpu_valid}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
